// File: rtl/putc_uart_tx.sv
// Console output stage: buffers putc characters in a small FIFO and
// serialises them as 8N1 UART frames on tx.
module putc_uart_tx #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       putc,
  input  logic [7:0] putc_char,
  input  logic       halted,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       drained
);

  // state   | meaning
  // S_IDLE  | line high, pop head of FIFO when one is waiting
  // S_START | start bit (low) for one bit time
  // S_DATA  | eight data bits, LSB first, one bit time each
  // S_STOP  | stop bit (high) for one bit time
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(CPB);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(CPB - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  state_t         state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [2:0]     bn_q, bn_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           push, pop, bc_last;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign busy     = !empty || (state_q != S_IDLE);
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign drained  = halted && !busy;

  // full is the pre-edge view, so a push in a pop cycle of a full FIFO is lost
  always_comb begin
    push       = putc && !full;
    overflow_d = overflow_q | (putc & full);
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = putc_char;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // tx_d follows the state being entered so tx is a clean registered output
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    bn_d    = bn_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bc_last = (bc_q == BC_LAST);
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bc_d    = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bc_last) begin
          bc_d    = '0;
          bn_d    = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      S_DATA: begin
        if (bc_last) begin
          bc_d    = '0;
          shift_d = shift_q >> 1;
          if (bn_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bn_d = bn_q + 3'd1;
            tx_d = shift_q[1];
          end
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      S_STOP: begin
        if (bc_last) begin
          bc_d    = '0;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bc_q       <= '0;
      bn_q       <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      bn_q       <= bn_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_putc_uart_tx.sv
// Randomised bench for putc_uart_tx with a frame-level reference model
// (queue of pending chars plus remaining cycles of the frame on the line).
module tb_putc_uart_tx;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       putc = 1'b0;
  logic [7:0] putc_char = 8'h00;
  logic       halted = 1'b0;
  logic       tx, full, empty, busy, overflow, drained;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mq[$];
  int         m_left = 0;
  logic [7:0] m_cur = 8'h00;

  always #5 clk = ~clk;

  putc_uart_tx #(.CLK_HZ(4), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .putc(putc), .putc_char(putc_char),
    .halted(halted), .tx(tx), .full(full), .empty(empty), .busy(busy),
    .overflow(overflow), .drained(drained)
  );

  function automatic logic exp_tx();
    int k, b;
    if (m_left == 0) return 1'b1;
    k = FRAME - m_left;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic exp_busy();
    return (mq.size() > 0) || (m_left > 0);
  endfunction

  // Drive one cycle (called at negedge), advance the model, return at next negedge.
  task automatic cycle(input bit p, input logic [7:0] c);
    bit was_full;
    putc = p;
    putc_char = c;
    if (!rst_n) begin
      mq.delete();
      m_left = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (m_left == 0 && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (p && !was_full) mq.push_back(c);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    putc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(0, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(0, 8'h00);
    cycle(1, 8'h5A);
    rst_n = 1'b1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got=%b exp=0", drained); end
  endtask

  task automatic test_single();
    logic [7:0] chars [3];
    chars[0] = 8'h41;
    chars[1] = 8'($urandom);
    chars[2] = 8'($urandom);
    for (int n = 0; n < 3; n++) begin
      int first_low;
      first_low = -1;
      cycle(1, chars[n]);
      for (int i = 1; i < 46; i++) begin
        if (tx === 1'b0 && first_low < 0) first_low = i;
        checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL single_tx ch=%h cyc=%0d got=%b exp=%b", chars[n], i, tx, exp_tx()); end
        checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy ch=%h cyc=%0d got=%b exp=%b", chars[n], i, busy, exp_busy()); end
        cycle(0, 8'h00);
      end
      checks++; if (first_low != 2) begin errors++; $display("FAIL single_latency ch=%h got=%0d exp=2", chars[n], first_low); end
      checks++; if (busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_idle_after busy=%b empty=%b exp busy=0 empty=1", busy, empty); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic       trace [90];
    logic [7:0] da, db;
    pa[0] = 8'h55; pb[0] = 8'hAA;
    pa[1] = 8'($urandom); pb[1] = 8'($urandom);
    for (int n = 0; n < 2; n++) begin
      cycle(1, pa[n]);
      cycle(1, pb[n]);
      for (int i = 0; i < 90; i++) begin
        trace[i] = tx;
        checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_tx idx=%0d got=%b exp=%b", i, tx, exp_tx()); end
        cycle(0, 8'h00);
      end
      for (int j = 0; j < 8; j++) begin
        da[j] = trace[CPB + CPB*j + 2];
        db[j] = trace[FRAME + 1 + CPB + CPB*j + 2];
      end
      checks++; if (da !== pa[n]) begin errors++; $display("FAIL b2b_first got=%h exp=%h", da, pa[n]); end
      checks++; if (db !== pb[n]) begin errors++; $display("FAIL b2b_second got=%h exp=%h", db, pb[n]); end
      checks++; if (trace[FRAME] !== 1'b1 || trace[FRAME+1] !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b%b exp=10", trace[FRAME], trace[FRAME+1]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] dec[$];
    logic [7:0] sh;
    int cnt;
    bit in_frame;
    cycle(1, 8'hFF);
    cycle(0, 8'h00);
    cycle(0, 8'h00);
    for (int k = 0; k < 17; k++) begin
      cycle(1, 8'(k));
      if (k == 15) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16 got=%b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full17 got=%b exp=1", full); end
    for (int n = 0; n < 60 && m_left != 0; n++) begin
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_tx0 got=%b exp=%b", tx, exp_tx()); end
      cycle(0, 8'h00);
    end
    in_frame = 0; cnt = 0; sh = 8'h00;
    for (int n = 0; n < 16*(FRAME+1) + 10; n++) begin
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_tx cyc=%0d got=%b exp=%b", n, tx, exp_tx()); end
      if (!in_frame) begin
        if (tx === 1'b0) begin in_frame = 1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt % CPB == 2 && cnt / CPB >= 1 && cnt / CPB <= 8) sh[cnt/CPB - 1] = tx;
        if (cnt == FRAME - 1) begin in_frame = 0; dec.push_back(sh); end
      end
      cycle(0, 8'h00);
    end
    checks++; if (dec.size() != 16) begin errors++; $display("FAIL ovf_frames got=%0d exp=16", dec.size()); end
    for (int k = 0; k < 16 && k < dec.size(); k++) begin
      checks++; if (dec[k] !== 8'(k)) begin errors++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", k, dec[k], 8'(k)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_halt_drain();
    int first_drained;
    do_reset();
    first_drained = -1;
    cycle(1, 8'h48);
    cycle(1, 8'h69);
    cycle(0, 8'h00);
    halted = 1'b1;
    for (int i = 3; i < 100; i++) begin
      if (drained === 1'b1 && first_drained < 0) first_drained = i;
      checks++; if (drained !== !exp_busy()) begin errors++; $display("FAIL halt_drained cyc=%0d got=%b exp=%b", i, drained, !exp_busy()); end
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL halt_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
      cycle(0, 8'h00);
    end
    checks++; if (first_drained != 1 + 2*(FRAME+1)) begin errors++; $display("FAIL halt_first got=%0d exp=%0d", first_drained, 1 + 2*(FRAME+1)); end
    halted = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    cycle(1, 8'($urandom));
    cycle(0, 8'h00);
    cycle(0, 8'h00);
    for (int k = 0; k < DEPTH; k++) cycle(1, 8'($urandom));
    for (int n = 0; n < 60 && m_left != 0; n++) cycle(0, 8'h00);
    checks++; if (m_left != 0 || full !== 1'b1) begin errors++; $display("FAIL fullpop_reach full=%b exp=1 left=%0d", full, m_left); end
    cycle(1, 8'hEE);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got=%b exp=1", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fullpop_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%b exp=0", empty); end
    for (int n = 0; n < DEPTH*(FRAME+1) + 10; n++) begin
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL fullpop_tx cyc=%0d got=%b exp=%b", n, tx, exp_tx()); end
      checks++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL fullpop_fullflag cyc=%0d got=%b", n, full); end
      cycle(0, 8'h00);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fullpop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    c = 8'($urandom);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf got=%b exp=1", overflow); end
    cycle(1, c);
    for (int i = 1; i < 19; i++) cycle(0, 8'h00);
    checks++; if (tx !== c[3]) begin errors++; $display("FAIL rmid_bit3 got=%b exp=%b", tx, c[3]); end
    rst_n = 1'b0;
    cycle(1, 8'h77);
    rst_n = 1'b1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx got=%b exp=1", tx); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%b exp=1", empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
    c = 8'($urandom);
    cycle(1, c);
    for (int i = 1; i < 46; i++) begin
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL rmid_frame cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
      cycle(0, 8'h00);
    end
  endtask

  task automatic test_random();
    bit p;
    for (int i = 0; i < 800; i++) begin
      p = ($urandom_range(0, 99) < 30);
      cycle(p, 8'($urandom));
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
      checks++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", i, full, mq.size() == DEPTH); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty cyc=%0d got=%b exp=%b", i, empty, mq.size() == 0); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy()); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_halt_drain();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
